// File: rtl/pokey_audio_out.sv
// POKEY channel audio output stage: polynomial counters, AUDC distortion select, volume register.
// Optional high-pass flip-flop is built only when AUDIO_HPF_EN is defined.
module pokey_audio_out (
    input  logic       clk,
    input  logic       nrst,
    input  logic       enn,
    input  logic       tick,
    input  logic [7:0] audc_d,
    input  logic       audc_wr,
    input  logic       poly9_sel,
    input  logic       poly_hold,
    input  logic       hpf_en,
    input  logic       hp_clk,
    output logic [3:0] vol_out,
    output logic       chan_q
);
    logic [7:0]  r_audc;
    logic [3:0]  r_poly4;
    logic [4:0]  r_poly5;
    logic [8:0]  r_poly9;
    logic [16:0] r_poly17;
    logic        r_chan_q;
    logic [3:0]  r_vol;
    logic        w_tick_eff;
    logic        w_chan_next;
    logic        w_o;

    // Effective tick and next channel bit, from pre-shift poly values and current AUDC
    always_comb begin
        w_tick_eff = tick & (r_audc[7] | r_poly5[4]);
        if (r_audc[5]) begin
            w_chan_next = ~r_chan_q;
        end else if (r_audc[6]) begin
            w_chan_next = r_poly4[3];
        end else if (poly9_sel) begin
            w_chan_next = r_poly9[8];
        end else begin
            w_chan_next = r_poly17[16];
        end
    end

`ifdef AUDIO_HPF_EN
    logic r_hp_q;

    // High-pass flip-flop samples the pre-update channel bit on partner borrow
    always_ff @(negedge clk or negedge nrst) begin
        if (!nrst) begin
            r_hp_q <= 1'b0;
        end else if (enn && hp_clk) begin
            r_hp_q <= r_chan_q;
        end else begin
            r_hp_q <= r_hp_q;
        end
    end

    assign w_o = r_chan_q ^ (hpf_en & r_hp_q);
`else
    logic w_unused_hpf;
    assign w_unused_hpf = hpf_en ^ hp_clk;
    assign w_o          = r_chan_q;
`endif

    // Free-running LFSRs; hold forces all-ones and wins over shifting
    always_ff @(negedge clk or negedge nrst) begin
        if (!nrst) begin
            r_poly4  <= 4'hF;
            r_poly5  <= 5'h1F;
            r_poly9  <= 9'h1FF;
            r_poly17 <= 17'h1FFFF;
        end else if (enn) begin
            if (poly_hold) begin
                r_poly4  <= 4'hF;
                r_poly5  <= 5'h1F;
                r_poly9  <= 9'h1FF;
                r_poly17 <= 17'h1FFFF;
            end else begin
                r_poly4  <= {r_poly4[2:0],   r_poly4[3]   ^ r_poly4[2]};
                r_poly5  <= {r_poly5[3:0],   r_poly5[4]   ^ r_poly5[2]};
                r_poly9  <= {r_poly9[7:0],   r_poly9[8]   ^ r_poly9[4]};
                r_poly17 <= {r_poly17[15:0], r_poly17[16] ^ r_poly17[11]};
            end
        end else begin
            r_poly4  <= r_poly4;
            r_poly5  <= r_poly5;
            r_poly9  <= r_poly9;
            r_poly17 <= r_poly17;
        end
    end

    // AUDC, channel flip-flop and volume sample; all read pre-update state
    always_ff @(negedge clk or negedge nrst) begin
        if (!nrst) begin
            r_audc   <= 8'h00;
            r_chan_q <= 1'b0;
            r_vol    <= 4'h0;
        end else if (enn) begin
            if (audc_wr) begin
                r_audc <= audc_d;
            end else begin
                r_audc <= r_audc;
            end
            if (w_tick_eff) begin
                r_chan_q <= w_chan_next;
            end else begin
                r_chan_q <= r_chan_q;
            end
            if (r_audc[4] || w_o) begin
                r_vol <= r_audc[3:0];
            end else begin
                r_vol <= 4'h0;
            end
        end else begin
            r_audc   <= r_audc;
            r_chan_q <= r_chan_q;
            r_vol    <= r_vol;
        end
    end

    assign vol_out = r_vol;
    assign chan_q  = r_chan_q;
endmodule

// File: doc/pokey_audio_out.md
# pokey_audio_out

Audio output stage for one POKEY channel, sitting directly downstream of the channel's down-counter cell chain. It consumes the chain's borrow pulse and applies the AUDC distortion selection:
- 4-, 5- and 9/17-bit polynomial counters,
- 5-bit gating,
- pure tone,
- volume-only mode,
- optional high-pass flip-flop.

It produces a registered 4-bit volume sample for the DAC/mixer.

## Interface
Parameters: none.

- clk  input  1  system clock; all state changes on the falling edge
- nrst  input  1  asynchronous active-low reset
- enn  input  1  clock-enable phase; state advances only on falling edges where enn=1 (an "enn cycle")
- tick  input  1  channel borrow pulse (BOR of the divider), one enn cycle wide
- audc_d  input  8  AUDC write data
- audc_wr  input  1  AUDC write strobe, sampled on an enn cycle
- poly9_sel  input  1  1 = 9-bit poly replaces 17-bit poly (AUDCTL bit 7)
- poly_hold  input  1  1 = all poly counters held at all-ones (SKCTL init)
- hpf_en  input  1  high-pass enable (only with AUDIO_HPF_EN)
- hp_clk  input  1  partner-channel borrow pulse clocking the high-pass flip-flop
- vol_out  output  4  registered volume sample
- chan_q  output  1  channel output flip-flop state

## Operation
- AUDC register: loads audc_d on an enn cycle with audc_wr=1. Field use:
  - bit7=0: gate ticks through poly5
  - bit6: 1 = poly4, else poly17/9
  - bit5: 1 = pure tone
  - bit4: volume-only
  - bits3:0: volume
- Poly counters free-run every enn cycle. Each shifts left; the new LSB is XOR of two taps; the output is the MSB.
  - poly4: taps b3^b2, period 15
  - poly5: taps b4^b2, period 31
  - poly9: taps b8^b4, period 511
  - poly17: taps b16^b11, period 131071
- poly_hold=1 forces all four to all-ones, taking priority over shifting.
- Effective tick: tick & (audc[7] | poly5_msb).
- On an effective tick, chan_q loads:
  - ~chan_q if audc[5]=1,
  - else poly4_msb if audc[6]=1,
  - else the poly9_sel ? poly9_msb : poly17_msb.
- Polynomial values are those before the same-cycle shift.
- High-pass flip-flop hp_q loads the current (pre-update) chan_q on an enn cycle with hp_clk=1. The output bit is o = chan_q ^ (hpf_en & hp_q).
- vol_out register is updated every enn cycle:
  - audc[3:0] if audc[4]=1,
  - else o ? audc[3:0] : 0.

## Timing
- Reset values: audc=0x00, chan_q=0, hp_q=0, vol_out=0, all poly counters all-ones.
- Reset is effective immediately. Releasing nrst mid-operation restarts from these values; the first enn cycle after release is the first advance.
- Latency:
  - tick to chan_q change: 1 enn cycle.
  - tick to vol_out: 2 enn cycles (vol_out samples registered chan_q).
  - audc_wr to vol_out reflecting the new volume: 2 enn cycles.
- audc_wr and tick in the same enn cycle: chan_q update uses the old AUDC value.
- tick and hp_clk in the same cycle: hp_q takes the old chan_q.
- Falling edges with enn=0 change nothing.
- tick held high across consecutive enn cycles is legal: one evaluation per enn cycle.

## Configuration
- AUDIO_HPF_EN defined: hp_q flip-flop present and operates as above.
- Not defined: hp_q, hpf_en and hp_clk logic removed; o = chan_q. hpf_en and hp_clk remain as ignored ports.

## Test plan
- Reset and idle:
  - Stimulus: assert nrst=0 mid-stream.
  - Required response: vol_out=0 and chan_q=0 immediately, held until the first enn cycle after release.
- Pure tone:
  - Stimulus: write 0xA8, tick every 4th enn cycle.
  - Required response: vol_out alternates 8/0, period 8 enn cycles, each change 2 enn cycles after a tick.
- Volume-only:
  - Stimulus: write 0x1F, with ticks running.
  - Required response: vol_out=15 from the 2nd enn cycle after the write, constant.
- Poly4:
  - Stimulus: write 0xC5, tick every enn cycle, poly_hold released at reset.
  - Required response: chan_q sequence repeats every 15 ticks with 8 ones and 7 zeros; vol_out is 5/0 accordingly.
- Poly5 gating:
  - Stimulus: write 0x28, tick every enn cycle for 31 cycles.
  - Required response: exactly 16 chan_q toggles. Setting poly_hold=1 gates every tick through (constant poly5_msb=1).
- High-pass (AUDIO_HPF_EN):
  - Stimulus: hpf_en=1, hp_clk=0, pure tone.
  - Required response: output identical to unfiltered. A single hp_clk pulse while chan_q=1 forces vol_out=0 until the next effective tick.
